// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types, defaults and helpers for the LOAD/STORE memory responder
package mem_if_pkg;

  // Default word width, words per line and access latency.
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 8;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_XFER    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_DONE    = 3'd4,
    ST_RELEASE = 3'd5
  } mem_state_e;

  // Address of the first word of the line containing addr (line_words is a power of two).
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned line_words);
    return addr & ~(64'(line_words) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word storage with synchronous write, combinational read, word[i] = i at time 0
module mem_word_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  typedef logic [DEPTH_WORDS-1:0][DATA_W-1:0] words_t;

  function automatic words_t init_words();
    words_t w;
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      w[i] = DATA_W'(i);
    end
    return w;
  endfunction

  // Contents start as word[i] = i and are never touched by reset.
  words_t mem_q = init_words();

  // Commit one word per enabled clock edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - main-memory responder serving held LOAD (line fill) and STORE (word write) requests
module main_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH_WORDS = 256,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ADDR_W-1:0]            input_address,
  input  logic                         LOAD,
  input  logic                         STORE,
  input  logic [DATA_W-1:0]            input_data,
  output logic [LINE_WORDS*DATA_W-1:0] line_data,
  output logic                         data_valid,
  output logic                         store_completed,
  output logic                         addr_error,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // A store spends its last latency cycle in COMMIT, so WAIT is one cycle shorter than for a load.
  localparam int STORE_WAIT_LAST = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam int LOAD_WAIT_LAST  = LATENCY - 1;

  mem_state_e                   state_q, state_d;
  logic                         op_store_q;
  logic                         oob_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            data_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [LW_BITS-1:0]           wcnt_q;
  logic [LINE_WORDS*DATA_W-1:0] buf_q, buf_d;
  logic [LINE_WORDS*DATA_W-1:0] line_q;

  logic                         accept;
  logic                         wait_last;
  logic                         xfer_last;
  logic                         mem_we;
  logic [IDX_W-1:0]             raddr;
  logic [DATA_W-1:0]            rdata;
  logic [DATA_W-1:0]            rd_word;

  assign accept    = (state_q == ST_IDLE) && (STORE || LOAD);
  assign wait_last = op_store_q ? (cnt_q == CNT_W'(STORE_WAIT_LAST))
                                : (cnt_q == CNT_W'(LOAD_WAIT_LAST));
  assign xfer_last = (wcnt_q == LW_BITS'(LINE_WORDS - 1));

  // Line words come from the aligned base of the in-range index, so they never wrap out of the line.
  assign raddr   = IDX_W'(line_base(64'(addr_q[IDX_W-1:0]), LINE_WORDS)) | IDX_W'(wcnt_q);
  assign rd_word = oob_q ? '0 : rdata;

  mem_word_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_words (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (data_q),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: STORE wins a tie; RELEASE holds until the served request line drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (STORE) begin
          state_d = (LATENCY == 1) ? ST_COMMIT : ST_WAIT;
        end else if (LOAD) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_last) begin
          state_d = op_store_q ? ST_COMMIT : ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer_last) begin
          state_d = ST_DONE;
        end
      end
      ST_COMMIT:  state_d = ST_DONE;
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!(op_store_q ? STORE : LOAD)) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: completion pulses live in DONE, the write happens on the edge that leaves COMMIT.
  always_comb begin
    busy            = (state_q != ST_IDLE);
    data_valid      = (state_q == ST_DONE) && !op_store_q;
    store_completed = (state_q == ST_DONE) && op_store_q;
    addr_error      = (state_q == ST_DONE) && oob_q;
    mem_we          = (state_q == ST_COMMIT) && !oob_q;
  end

  // Line buffer with the word read this cycle merged into its slot.
  always_comb begin
    buf_d = buf_q;
    buf_d[int'(wcnt_q)*DATA_W +: DATA_W] = rd_word;
  end

  // Request latch, latency/word counters and line assembly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_store_q <= 1'b0;
      oob_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      buf_q      <= '0;
      line_q     <= '0;
    end else begin
      if (accept) begin
        op_store_q <= STORE;
        oob_q      <= (64'(input_address) >= 64'(DEPTH_WORDS));
        addr_q     <= input_address;
        data_q     <= input_data;
        cnt_q      <= '0;
        wcnt_q     <= '0;
      end
      if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_XFER) begin
        buf_q  <= buf_d;
        wcnt_q <= wcnt_q + 1'b1;
        if (xfer_last) begin
          line_q <= buf_d;
        end
      end
    end
  end

  assign line_data = line_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - self-checking bench for main_mem_responder
module tb_main_mem_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int LW     = 4;
  localparam int LAT    = 8;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic [ADDR_W-1:0]    input_address = '0;
  logic                 LOAD = 1'b0;
  logic                 STORE = 1'b0;
  logic [DATA_W-1:0]    input_data = '0;
  logic [LW*DATA_W-1:0] line_data;
  logic                 data_valid;
  logic                 store_completed;
  logic                 addr_error;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];

  always #5 CLK = ~CLK;

  main_mem_responder #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH),
    .LINE_WORDS  (LW),
    .LATENCY     (LAT)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .input_address   (input_address),
    .LOAD            (LOAD),
    .STORE           (STORE),
    .input_data      (input_data),
    .line_data       (line_data),
    .data_valid      (data_valid),
    .store_completed (store_completed),
    .addr_error      (addr_error),
    .busy            (busy)
  );

  function automatic logic [LW*DATA_W-1:0] model_line(input logic [ADDR_W-1:0] a);
    logic [LW*DATA_W-1:0] l;
    int base;
    l = '0;
    if (a >= DEPTH) return l;
    base = (int'(a) / LW) * LW;
    for (int k = 0; k < LW; k++) l[k*DATA_W +: DATA_W] = model_mem[base + k];
    return l;
  endfunction

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int j = 0; j < 4 && !idle; j++) begin
      @(posedge CLK); #1;
      if (busy === 1'b0) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL %s return_to_idle got busy=%b want 0", name, busy);
    end
  endtask

  // One request (STORE or LOAD alone), held for `hold` cycles after the pulse.
  task automatic run_req(input bit st, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int hold, input string name);
    int pulse_at;
    bit oob;
    logic [LW*DATA_W-1:0] exp_line;
    oob      = (a >= DEPTH);
    pulse_at = st ? LAT : LAT + LW;
    exp_line = model_line(a);
    @(posedge CLK); #1;
    input_address = a; input_data = d; STORE = st; LOAD = !st;
    for (int k = 0; k <= pulse_at + hold; k++) begin
      @(posedge CLK); #1;
      if (k == 2) begin
        input_address = $urandom;
        input_data    = $urandom;
      end
      checks++;
      if (data_valid !== (!st && k == pulse_at)) begin
        errors++;
        $display("FAIL %s data_valid at E%0d got=%b want=%b", name, k, data_valid, (!st && k == pulse_at));
      end
      checks++;
      if (store_completed !== (st && k == pulse_at)) begin
        errors++;
        $display("FAIL %s store_completed at E%0d got=%b want=%b", name, k, store_completed, (st && k == pulse_at));
      end
      checks++;
      if (addr_error !== (oob && k == pulse_at)) begin
        errors++;
        $display("FAIL %s addr_error at E%0d got=%b want=%b", name, k, addr_error, (oob && k == pulse_at));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy at E%0d got=%b want=1", name, k, busy);
      end
      if (!st && k == pulse_at) begin
        checks++;
        if (line_data !== exp_line) begin
          errors++;
          $display("FAIL %s line_data got=%h want=%h", name, line_data, exp_line);
        end
      end
    end
    STORE = 1'b0; LOAD = 1'b0;
    wait_idle(name);
    if (st && !oob) model_mem[a] = d;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #3 RST = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b want 0", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset data_valid got=%b want 0", data_valid); end
    checks++; if (store_completed !== 1'b0) begin errors++; $display("FAIL reset store_completed got=%b want 0", store_completed); end
    checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL reset addr_error got=%b want 0", addr_error); end
    checks++; if (line_data !== '0) begin errors++; $display("FAIL reset line_data got=%h want 0", line_data); end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_load_basic();
    run_req(1'b0, 32'h08, 32'h0, 1, "load_08");
  endtask

  task automatic test_store_then_load();
    run_req(1'b1, 32'h19, 32'hDEADBEEF, 0, "store_19");
    run_req(1'b0, 32'h1A, 32'h0, 0, "load_1a");
  endtask

  // STORE wins the tie; the held LOAD is served once STORE drops and the FSM is idle again.
  task automatic test_both_high();
    int sc_n, dv_n, sc_at, dv_at, dv_want;
    logic [LW*DATA_W-1:0] exp_line, got_line;
    sc_n = 0; dv_n = 0; sc_at = -1; dv_at = -1; got_line = '0;
    model_mem[5] = 32'h55;
    exp_line = model_line(32'h05);
    // store pulse, DONE->RELEASE, RELEASE->IDLE, then a fresh accept edge and a full load
    dv_want = LAT + 3 + LAT + LW;
    @(posedge CLK); #1;
    input_address = 32'h05; input_data = 32'h55; STORE = 1'b1; LOAD = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge CLK); #1;
      if (store_completed === 1'b1) begin sc_n++; sc_at = k; end
      if (data_valid === 1'b1) begin dv_n++; dv_at = k; got_line = line_data; end
      if (k == LAT) STORE = 1'b0;
    end
    checks++; if (sc_n != 1) begin errors++; $display("FAIL both store_pulses got=%0d want 1", sc_n); end
    checks++; if (sc_at != LAT) begin errors++; $display("FAIL both store_edge got=%0d want %0d", sc_at, LAT); end
    checks++; if (dv_n != 1) begin errors++; $display("FAIL both load_pulses got=%0d want 1", dv_n); end
    checks++; if (dv_at != dv_want) begin errors++; $display("FAIL both load_edge got=%0d want %0d", dv_at, dv_want); end
    checks++; if (got_line !== exp_line) begin errors++; $display("FAIL both line got=%h want=%h", got_line, exp_line); end
    LOAD = 1'b0;
    wait_idle("both");
  endtask

  task automatic test_hold_long();
    run_req(1'b0, 32'($urandom_range(0, DEPTH - 1)), 32'h0, 40, "hold_long");
  endtask

  task automatic test_out_of_range();
    run_req(1'b0, 32'h100, 32'h0, 0, "oob_load");
    run_req(1'b1, 32'h100, 32'hCAFEF00D, 0, "oob_store");
    run_req(1'b0, 32'h00, 32'h0, 0, "oob_check_word0");
  endtask

  task automatic test_reset_mid_store();
    @(posedge CLK); #1;
    input_address = 32'h10; input_data = 32'h77; STORE = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got=%b want 0", busy); end
    checks++; if (line_data !== '0) begin errors++; $display("FAIL rst_mid line_data got=%h want 0", line_data); end
    STORE = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      checks++;
      if ((store_completed | data_valid | addr_error) !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid pulse got sc=%b dv=%b ae=%b want 0", store_completed, data_valid, addr_error);
      end
    end
    RST = 1'b0;
    run_req(1'b0, 32'h10, 32'h0, 0, "rst_reload_10");
  endtask

  task automatic test_random();
    bit st;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 24; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'h100 + 32'($urandom_range(0, 31));
      else a = 32'($urandom_range(0, DEPTH - 1));
      run_req(st, a, $urandom, int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(i);
    test_reset();
    test_load_basic();
    test_store_then_load();
    test_both_high();
    test_hold_long();
    test_out_of_range();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
